// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out framing receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int cyc_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    function automatic int bit_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Right-shifting capture register: each new serial bit enters at the MSB,
// so the first bit received ends up at the LSB.
module sipo_shift
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             shift_en,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n)      q <= '0;
                else if (shift_en) q <= si;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n)      q <= '0;
                else if (shift_en) q <= {si, q[WIDTH-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framing controller: finds the start bit, samples data bits at mid-bit,
// checks the stop bit and presents the word over a valid/ready handshake.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
    localparam int CYC_W    = cyc_width(CLKS_PER_BIT);
    localparam int BIT_W    = bit_width(WIDTH);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t             state, state_d;
    logic [CYC_W-1:0]   cyc, cyc_d;
    logic [BIT_W-1:0]   bit_cnt, bit_d;
    logic               shift_en;
    logic               stop_tick;
    logic [WIDTH-1:0]   shift_q;
    logic               load, drop, bad_stop, accept;

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .clear_n  (clear_n),
        .shift_en (shift_en),
        .si       (si),
        .q        (shift_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            cyc     <= cyc_d;
            bit_cnt <= bit_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state;
        cyc_d     = (cyc == CYC_LAST) ? '0 : cyc + CYC_W'(1);
        bit_d     = bit_cnt;
        shift_en  = 1'b0;
        stop_tick = 1'b0;
        unique case (state)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (!si) state_d = START;
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cyc == CYC_HALF) begin
                    cyc_d   = '0;
                    state_d = si ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc == CYC_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (cyc == CYC_LAST) begin
                    stop_tick = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept   = po_valid & po_ready;
    assign load     = stop_tick & si & (~po_valid | po_ready);
    assign drop     = stop_tick & si & po_valid & ~po_ready;
    assign bad_stop = stop_tick & ~si;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            po        <= '0;
            po_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (load) begin
                po       <= shift_q;
                po_valid <= 1'b1;
            end else if (accept) begin
                po_valid <= 1'b0;
            end
            // A fresh drop outranks a simultaneous clear request.
            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl (WIDTH=4, CLKS_PER_BIT=4): table of frames
// plus hand-written overrun, glitch and mid-frame reset sequences.
module tb_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       si;
    logic       po_ready;
    logic       ovr_clr;
    logic [3:0] po;
    logic       po_valid;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    sipo_rx_ctrl #(.WIDTH(4), .CLKS_PER_BIT(4)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .si        (si),
        .po        (po),
        .po_valid  (po_valid),
        .po_ready  (po_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       stop_bit;
        logic [3:0] exp_po;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one frame (start, 4 data bits LSB first, stop), 4 cycles per bit,
    // then idle_after idle cycles. Cycle c is sampled by DUT edge E0+c.
    // clr_at / rdy_at pulse ovr_clr / po_ready during that single cycle.
    task automatic run_frame(input logic [3:0] data, input logic stop_bit, input int idle_after,
                             input int clr_at, input int rdy_at,
                             output int valid_cnt, output int valid_first, output int ferr_cnt);
        valid_cnt   = 0;
        valid_first = -1;
        ferr_cnt    = 0;
        for (int c = 0; c < 24 + idle_after; c++) begin
            int b;
            b = c / 4;
            if (b == 0)      si = 1'b0;
            else if (b <= 4) si = data[b-1];
            else if (b == 5) si = stop_bit;
            else             si = 1'b1;
            ovr_clr = (c == clr_at);
            if (rdy_at >= 0) po_ready = (c == rdy_at);
            @(posedge clk);
            @(negedge clk);
            if (po_valid === 1'b1) begin
                valid_cnt++;
                if (valid_first < 0) valid_first = c;
            end
            if (frame_err === 1'b1) ferr_cnt++;
        end
        ovr_clr = 1'b0;
        si      = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vc, vf, fc, bad;

        vecs[0] = '{data: 4'b1101, stop_bit: 1'b1, exp_po: 4'hD, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 4'b0110, stop_bit: 1'b0, exp_po: 4'hD, exp_valid: 1'b0, exp_ferr: 1'b1};
        vecs[2] = '{data: 4'h3,    stop_bit: 1'b1, exp_po: 4'h3, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 4'h0,    stop_bit: 1'b1, exp_po: 4'h0, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 4'hF,    stop_bit: 1'b1, exp_po: 4'hF, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[5] = '{data: 4'h8,    stop_bit: 1'b0, exp_po: 4'hF, exp_valid: 1'b0, exp_ferr: 1'b1};

        clear_n  = 1'b0;
        si       = 1'b1;
        po_ready = 1'b1;
        ovr_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_po", po, 4'h0);
        check("reset_po_valid", po_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        clear_n = 1'b1;

        // Idle line stays quiet.
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (po !== 4'h0 || po_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // Table of frames with po_ready=1.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].stop_bit, 3, -1, -1, vc, vf, fc);
            check($sformatf("vec%0d_valid_cycles", i), vc, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) check($sformatf("vec%0d_valid_at", i), vf, 22);
            check($sformatf("vec%0d_ferr_cycles", i), fc, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_po", i), po, vecs[i].exp_po);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
        end

        // Overrun: consumer stalled, back-to-back frames A then 5.
        po_ready = 1'b0;
        run_frame(4'hA, 1'b1, 0, -1, -1, vc, vf, fc);
        check("ovr_first_po", po, 4'hA);
        check("ovr_first_valid", po_valid, 1);
        check("ovr_first_overrun", overrun, 0);
        run_frame(4'h5, 1'b1, 4, -1, -1, vc, vf, fc);
        check("ovr_second_po", po, 4'hA);
        check("ovr_second_valid", po_valid, 1);
        check("ovr_second_overrun", overrun, 1);
        ovr_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr_overrun", overrun, 0);
        check("ovr_clr_po", po, 4'hA);

        // Clear requested on the very edge a word is dropped: set wins.
        run_frame(4'hC, 1'b1, 2, 22, -1, vc, vf, fc);
        check("setwins_overrun", overrun, 1);
        check("setwins_po", po, 4'hA);

        // Accept and load on the same edge: new word replaces, valid stays.
        run_frame(4'h6, 1'b1, 2, -1, 22, vc, vf, fc);
        check("swap_po", po, 4'h6);
        check("swap_valid", po_valid, 1);
        check("swap_overrun", overrun, 1);
        po_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("drain_valid", po_valid, 0);
        check("drain_po", po, 4'h6);

        // One-cycle low glitch is rejected silently.
        si = 1'b0;
        @(posedge clk);
        @(negedge clk);
        si = 1'b1;
        vc = 0;
        fc = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (po_valid === 1'b1) vc++;
            if (frame_err === 1'b1) fc++;
        end
        check("glitch_valid_cycles", vc, 0);
        check("glitch_ferr_cycles", fc, 0);
        check("glitch_po", po, 4'h6);
        check("glitch_overrun", overrun, 1);

        // Reset asserted mid-DATA aborts the frame and clears outputs at once.
        for (int c = 0; c < 12; c++) begin
            si = (c < 4) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        clear_n = 1'b0;
        si      = 1'b1;
        #1;
        check("midreset_po", po, 4'h0);
        check("midreset_valid", po_valid, 0);
        check("midreset_ferr", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_valid", po_valid, 0);
        run_frame(4'h3, 1'b1, 3, -1, -1, vc, vf, fc);
        check("post_reset_valid_cycles", vc, 1);
        check("post_reset_valid_at", vf, 22);
        check("post_reset_po", po, 4'h3);
        check("post_reset_ferr", fc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Framing controller that sequences a serial-in/parallel-out shift register.
- Watches serial line `si` for a start bit and samples WIDTH data bits LSB-first at mid-bit.
- Checks the stop bit, then hands the assembled word to downstream logic over a valid/ready handshake.
- Sits between a raw serial pin and the parallel consumer; owns the shift datapath as one sub-module.

Parameters:
- WIDTH, 4, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clk cycles per serial bit (even, >=2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clear_n  input  1  asynchronous active-low reset.
- si  input  1  serial data in; idle high; already synchronous to clk.
- po  output  WIDTH  received word, LSB = first data bit; held stable while po_valid=1.
- po_valid  output  1  word available.
- po_ready  input  1  consumer accepts po on an edge where po_valid&po_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: completed word dropped because the holding register was full.
- ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE; po=0, po_valid=0, frame_err=0, overrun=0.
  - Bit counter, cycle counter and shift register all 0.
  - Reset mid-frame aborts the frame; no partial word is ever presented.
- States: IDLE, START, DATA, STOP.
- IDLE: si=0 sampled at edge E0 -> START, cycle counter cleared.
- START:
  - At E0+CLKS_PER_BIT/2, si=0 -> DATA.
  - If si=1 there (glitch) -> IDLE; no error is flagged.
- DATA:
  - Bit k (k=0..WIDTH-1) sampled at E0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - Shift register shifts right with the new bit entering the MSB, so after WIDTH bits bit 0 sits at LSB.
  - After bit WIDTH-1 -> STOP.
- STOP:
  - Stop bit sampled at E0+CLKS_PER_BIT/2+(WIDTH+1)*CLKS_PER_BIT; always -> IDLE on that edge.
  - si=1 and holding register free, or being accepted on this same edge: po<=shift register, po_valid=1 from the next cycle.
  - si=1 and po_valid=1 and po_ready=0: new word dropped, po unchanged, overrun<=1.
  - si=0: frame_err=1 for exactly one cycle, word discarded, po/po_valid unaffected.
- A new start bit is accepted in the IDLE cycle immediately after STOP (back-to-back frames). Since STOP exits to IDLE at the mid-stop-bit sample edge, the earliest next E0 is one cycle after that edge.
- Handshake:
  - po_valid clears on the edge where po_valid&po_ready, unless a new word loads on that same edge; then po is replaced and po_valid stays 1.
  - po_ready while po_valid=0 is ignored.
- Overrun:
  - Stays 1 until reset or ovr_clr=1.
  - If ovr_clr and a new overrun coincide, overrun=1 (set wins).
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.
  - Bit counter is $clog2(WIDTH+1) bits.
  - No arithmetic overflow is reachable.

Decomposition:
- Package sipo_rx_pkg holds:
  - state enum (IDLE=0, START=1, DATA=2, STOP=3);
  - localparam helpers HALF_BIT=CLKS_PER_BIT/2 and counter widths.
- One sub-module, sipo_shift:
  - ports clk, clear_n, shift_en, si, q[WIDTH-1:0];
  - right-shifting register loaded from si when shift_en=1, asynchronously cleared.
- Controller FSM, counters, holding register and flags live in sipo_rx_ctrl.

Test Plan (WIDTH=4, CLKS_PER_BIT=4, po_ready=1 unless stated):
1. Reset then idle si=1 for 20 cycles -> po=0, po_valid=0, frame_err=0, overrun=0 throughout.
2. Frame start 0, data 1,0,1,1 (LSB first), stop 1, each bit held 4 cycles -> po=4'b1101, po_valid high for exactly 1 cycle, beginning one cycle after edge E0+22.
3. Stop bit driven 0 after data 0,1,1,0 -> frame_err pulses once, po_valid stays 0, po unchanged.
4. po_ready=0, two back-to-back valid frames 4'hA then 4'h5 -> po stays 4'hA, overrun=1; ovr_clr pulse -> overrun=0.
5. Single-cycle-wide 0 glitch on si (shorter than 2 cycles) -> FSM returns to IDLE, no po_valid, no frame_err.
6. clear_n pulsed low during DATA of a frame -> all outputs 0 immediately; a following clean frame 4'h3 is received correctly.
